// File: rtl/mdu_ctrl_if.sv
// Pipeline-side handshake and HI/LO bus of the multiply/divide unit controller.
// The master drives issue/operands; the slave (the MDU) returns status and HI/LO.
interface mdu_ctrl_if;
   logic        Req;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        md_use;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Req, start, op, A, B, md_use,
      input  busy, stall, done, HI, LO
   );

   modport slave (
      input  Req, start, op, A, B, md_use,
      output busy, stall, done, HI, LO
   );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: models fixed MULT/DIV latency with a down-counter
// and commits the 64-bit result to HI/LO on completion.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_ctrl_if.slave  bus
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [0:0]       state;
   logic [CNT_W-1:0] count;
   logic [2:0]       op_lat;
   logic [31:0]      a_lat;
   logic [31:0]      b_lat;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic             done;

   logic             accept;
   logic             is_long;
   logic             finish;
   logic             write_res;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;

   logic [63:0]      prod;
   logic             neg_a;
   logic             neg_b;
   logic [31:0]      num;
   logic [31:0]      den;
   logic [31:0]      quo;
   logic [31:0]      rem;

   assign accept  = bus.start & ~bus.Req & (state == IDLE);
   assign is_long = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
   assign finish  = (state == BUSY) && (count == CNT_W'(1));

   assign bus.busy  = (state == BUSY);
   assign bus.stall = bus.md_use & ((state == BUSY) | (bus.start & ~bus.Req & is_long));
   assign bus.done  = done;
   assign bus.HI    = hi;
   assign bus.LO    = lo;

   // Signed division runs on magnitudes so the 0x80000000 / -1 case needs no special path.
   always_comb begin
      neg_a     = 1'b0;
      neg_b     = 1'b0;
      num       = a_lat;
      den       = b_lat;
      quo       = '0;
      rem       = '0;
      prod      = '0;
      res_hi    = hi;
      res_lo    = lo;
      write_res = 1'b0;
      case (op_lat)
         OP_MULT: begin
            prod   = {{32{a_lat[31]}}, a_lat} * {{32{b_lat[31]}}, b_lat};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            write_res = finish;
         end
         OP_MULTU: begin
            prod   = {32'd0, a_lat} * {32'd0, b_lat};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            write_res = finish;
         end
         OP_DIV, OP_DIVU: begin
            if (op_lat == OP_DIV) begin
               neg_a = a_lat[31];
               neg_b = b_lat[31];
               num   = neg_a ? (32'd0 - a_lat) : a_lat;
               den   = neg_b ? (32'd0 - b_lat) : b_lat;
            end
            if (den != 32'd0) begin
               quo = num / den;
               rem = num % den;
            end
            res_lo    = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
            res_hi    = neg_a ? (32'd0 - rem) : rem;
            write_res = finish & (b_lat != 32'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         op_lat <= '0;
         a_lat  <= '0;
         b_lat  <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= finish;
         if (state == IDLE) begin
            if (accept) begin
               case (bus.op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     op_lat <= bus.op;
                     a_lat  <= bus.A;
                     b_lat  <= bus.B;
                     state  <= BUSY;
                     count  <= (bus.op == OP_MULT || bus.op == OP_MULTU) ?
                               CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  end
                  OP_MTHI: hi <= bus.A;
                  OP_MTLO: lo <= bus.A;
                  default: ;
               endcase
            end
         end else begin
            count <= count - CNT_W'(1);
            if (finish) begin
               state <= IDLE;
               if (write_res) begin
                  hi <= res_hi;
                  lo <= res_lo;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: issued long ops push expected {HI,LO}; a monitor
// pops and compares on every done pulse.
module tb_mdu_ctrl;
   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_val;

   always #5 clk = ~clk;

   mdu_ctrl_if bus ();

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.Req   = req;
      bus.start = 1'b1;
   endtask

   task automatic idleInputs();
      bus.start = 1'b0;
      bus.Req   = 1'b0;
      bus.op    = OP_NONE;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where done is visible.
   task automatic runLong(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [63:0] expected);
      int cnt;
      applyStimulus(op, a, b, 1'b0);
      #1 checkOutput({name, "_stall_accept"}, 64'(bus.stall), 64'(bus.md_use));
      exp_q.push_back(expected);
      @(negedge clk);
      idleInputs();
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.busy !== 1'b1) break;
         cnt++;
         checkOutput({name, "_stall_busy"}, 64'(bus.stall), 64'(bus.md_use));
         if (i == 1) applyStimulus(OP_MULTU, 32'h5, 32'h5, 1'b0);
         else if (i == 2) idleInputs();
         @(negedge clk);
      end
      checkOutput({name, "_busy_cycles"}, 64'(cnt), 64'(n));
      checkOutput({name, "_stall_after"}, 64'(bus.stall), 64'd0);
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: got done=1 with HI/LO 0x%0h, required no pending result",
                     {bus.HI, bus.LO});
         end else begin
            exp_val = exp_q.pop_front();
            checkOutput("hilo_commit", {bus.HI, bus.LO}, exp_val);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      bus.md_use = 1'b1;
      bus.A      = '0;
      bus.B      = '0;
      idleInputs();
      repeat (2) @(negedge clk);
      checkOutput("reset_busy",  64'(bus.busy),  64'd0);
      checkOutput("reset_done",  64'(bus.done),  64'd0);
      checkOutput("reset_stall", 64'(bus.stall), 64'd0);
      checkOutput("reset_hilo",  {bus.HI, bus.LO}, 64'd0);
      reset = 1'b0;

      runLong("mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'h3,        5,  {32'hFFFFFFFF, 32'hFFFFFFFA});
      runLong("multu_big",  OP_MULTU, 32'hFFFFFFFF, 32'h2,        5,  {32'h00000001, 32'hFFFFFFFE});
      runLong("mult_m1m1",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  {32'h00000000, 32'h00000001});
      runLong("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h2,        10, {32'hFFFFFFFF, 32'hFFFFFFFD});
      runLong("divu_zero",  OP_DIVU,  32'h7,        32'h0,        10, {32'hFFFFFFFF, 32'hFFFFFFFD});
      runLong("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, {32'h00000000, 32'h80000000});
      runLong("div_negneg", OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 10, {32'hFFFFFFFF, 32'h00000003});
      runLong("divu_16",    OP_DIVU,  32'hFFFFFFFF, 32'h10,       10, {32'h0000000F, 32'h0FFFFFFF});
      bus.md_use = 1'b0;
      runLong("multu_nouse", OP_MULTU, 32'h3, 32'h4, 5, {32'h00000000, 32'h0000000C});
      bus.md_use = 1'b1;

      applyStimulus(OP_MTHI, 32'h12345678, 32'h0, 1'b1);
      #1 checkOutput("mthi_req_stall", 64'(bus.stall), 64'd0);
      @(negedge clk);
      idleInputs();
      checkOutput("mthi_req_hi",   64'(bus.HI),   64'h0);
      checkOutput("mthi_req_busy", 64'(bus.busy), 64'd0);
      applyStimulus(OP_MTHI, 32'h12345678, 32'h0, 1'b0);
      @(negedge clk);
      idleInputs();
      checkOutput("mthi_hi",   64'(bus.HI),   64'h12345678);
      checkOutput("mthi_busy", 64'(bus.busy), 64'd0);
      checkOutput("mthi_done", 64'(bus.done), 64'd0);
      applyStimulus(OP_MTLO, 32'hCAFEBABE, 32'h0, 1'b0);
      @(negedge clk);
      idleInputs();
      checkOutput("mtlo_hilo", {bus.HI, bus.LO}, {32'h12345678, 32'hCAFEBABE});

      applyStimulus(OP_MULT, 32'h2, 32'h2, 1'b1);
      #1 checkOutput("mult_req_stall", 64'(bus.stall), 64'd0);
      @(negedge clk);
      idleInputs();
      checkOutput("mult_req_busy", 64'(bus.busy), 64'd0);
      applyStimulus(OP_RSVD, 32'hFFFFFFFF, 32'h1, 1'b0);
      @(negedge clk);
      applyStimulus(OP_NONE, 32'hFFFFFFFF, 32'h1, 1'b0);
      @(negedge clk);
      idleInputs();
      checkOutput("noop_busy", 64'(bus.busy), 64'd0);
      checkOutput("noop_hilo", {bus.HI, bus.LO}, {32'h12345678, 32'hCAFEBABE});

      applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      idleInputs();
      checkOutput("abort_busy_pre", 64'(bus.busy), 64'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", 64'(bus.busy), 64'd0);
      checkOutput("abort_hilo", {bus.HI, bus.LO}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (14) @(negedge clk);
      checkOutput("abort_hilo_later", {bus.HI, bus.LO}, 64'd0);
      checkOutput("abort_busy_later", 64'(bus.busy), 64'd0);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      runLong("post_reset", OP_MULT, 32'h3, 32'h4, 5, {32'h00000000, 32'h0000000C});

      repeat (3) @(negedge clk);
      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for DIV/DIVU.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  reset is asynchronous and active-high.
REQ-005 Req  in  1  exception/interrupt flush of the instruction currently in E.
REQ-006 start  in  1  E-stage instruction issues an MDU op this cycle.
REQ-007 op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 reserved.
REQ-008 A  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
REQ-009 B  in  32  rt operand (divisor / multiplier).
REQ-010 md_use  in  1  D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-011 busy  out  1  multi-cycle operation in flight.
REQ-012 stall  out  1  freeze request to the D/E pipeline-register write enables.
REQ-013 done  out  1  one-cycle pulse: result committed to HI/LO.
REQ-014 HI  out  32  HI register.
REQ-015 LO  out  32  LO register.

Function
REQ-016 Two states, IDLE and BUSY, plus a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-017 Accept = start & ~Req & (state == IDLE); start with Req=1 or in BUSY is ignored and leaves no state change.
REQ-018 Accepted MULT/MULTU/DIV/DIVU: latch op, A, B; enter BUSY; load counter with MULT_CYCLES or DIV_CYCLES.
REQ-019 busy = 1 exactly N cycles (N = selected parameter), starting the cycle after the accepting edge.
REQ-020 BUSY: counter decrements each edge; on the edge where it reaches zero, write HI/LO, return to IDLE, set done=1 for the following cycle only.
REQ-021 Accepted MTHI/MTLO: HI (resp. LO) <= A at the accepting edge; no BUSY; done stays 0.
REQ-022 op 000 or 111 with start=1: no effect.
REQ-023 MULT: {HI,LO} = signed 64-bit A*B; MULTU: unsigned 64-bit product.
REQ-024 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-026 Divisor 0 (DIV/DIVU): full DIV_CYCLES busy period; HI/LO unchanged at completion; done still pulses.
REQ-027 Req while BUSY does not cancel; in-flight op completes and commits.
REQ-028 stall = md_use & (busy | (start & ~Req & op in MULT..DIVU)); combinational.
REQ-029 HI/LO otherwise hold; only the completion edge or an accepted MTHI/MTLO writes them.
REQ-030 Operands used for the result are the latched copies; A/B changes during BUSY have no effect.

Reset
REQ-031 reset=1 asynchronously forces state IDLE, counter 0, busy=0, done=0, HI=0, LO=0, latched operands 0.
REQ-032 reset asserted mid-BUSY aborts the operation; no HI/LO write and no done pulse after release.
REQ-033 First edge after reset release may accept a start.

Verification
REQ-034 MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done one cycle.
REQ-035 MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI/LO unchanged, done pulses.
REQ-037 MULT accepted, md_use=1 during BUSY -> stall=1 on accept cycle and all 5 busy cycles, 0 after; second start during BUSY ignored.
REQ-038 start=1 op=MTHI A=0x12345678 with Req=1 -> HI unchanged; same with Req=0 -> HI=0x12345678 next cycle, busy stays 0.
REQ-039 reset pulsed in 3rd cycle of DIV -> busy=0 immediately, HI=LO=0, no done pulse afterwards.
